// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requests onto a single fixed-latency memory port.
// Optional fetch starvation guard: define MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic        IGnt,
  output logic        IValid,
  output logic [31:0] IData,
  input  logic        DReq,
  input  logic        DWr,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  output logic        DGnt,
  output logic        DValid,
  output logic [31:0] DRData,
  output logic [31:0] MemAddr,
  output logic        MemWr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  output logic        Busy
);

  // state  | meaning
  // IDLE   | no access in flight; arbitrate on sampled requests
  // ACCESS | latched address on memory port, grant pulse, write strobe
  // WAIT   | read latency countdown
  // RESP   | valid pulse with captured read data
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
      $error("mem_port_arbiter: MEM_LAT must be within 1..15");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve_max
      $error("mem_port_arbiter: STARVE_MAX must fit the 3-bit starve counter (1..7)");
    end
  endgenerate

  // WAIT exits on terminal count 0, so the load value is one less than its cycle count.
  localparam logic [3:0] WAIT_LOAD = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

  logic [1:0]  state;
  logic        sel_fetch;
  logic        lat_wr;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  wait_cnt;
  logic        starve_hit;
  logic        pick_fetch;
  logic        mem_drive;

  assign pick_fetch = IReq && (!DReq || starve_hit);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      sel_fetch <= 1'b0;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      IData     <= '0;
      DRData    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (IReq || DReq) begin
            state     <= ST_ACCESS;
            sel_fetch <= pick_fetch;
            lat_wr    <= !pick_fetch && DWr;
            lat_addr  <= pick_fetch ? IAddr : DAddr;
            lat_wdata <= pick_fetch ? 32'd0 : DWData;
          end
        end
        ST_ACCESS: begin
          if (lat_wr) begin
            state  <= ST_RESP;
            DRData <= '0;
          end else if (MEM_LAT == 1) begin
            state <= ST_RESP;
            if (sel_fetch) IData  <= MemRData;
            else           DRData <= MemRData;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_RESP;
            if (sel_fetch) IData  <= MemRData;
            else           DRData <= MemRData;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  logic [2:0] starve_cnt;

  assign starve_hit = (starve_cnt == STARVE_LIM);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE && (IReq || DReq)) begin
      if (pick_fetch || !IReq) starve_cnt <= '0;
      else                     starve_cnt <= starve_cnt + 3'd1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  assign mem_drive = (state == ST_ACCESS) || (state == ST_WAIT);
  assign Busy      = (state != ST_IDLE);
  assign IGnt      = (state == ST_ACCESS) && sel_fetch;
  assign DGnt      = (state == ST_ACCESS) && !sel_fetch;
  assign MemWr     = (state == ST_ACCESS) && lat_wr;
  assign MemAddr   = mem_drive ? lat_addr  : 32'd0;
  assign MemWData  = mem_drive ? lat_wdata : 32'd0;
  assign IValid    = (state == ST_RESP) && sel_fetch;
  assign DValid    = (state == ST_RESP) && !sel_fetch;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam int STARVE = 4;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        IReq = 1'b0;
  logic [31:0] IAddr = '0;
  logic        DReq = 1'b0;
  logic        DWr = 1'b0;
  logic [31:0] DAddr = '0;
  logic [31:0] DWData = '0;

  logic        IGnt, IValid, DGnt, DValid, MemWr, Busy;
  logic [31:0] IData, DRData, MemAddr, MemWData, MemRData;
  logic        q_ignt, q_ivalid, q_dgnt, q_dvalid, q_memwr, q_busy;
  logic [31:0] q_idata, q_drdata, q_memaddr, q_memwdata, q_memrdata;

  int n_checks = 0;
  int n_fail = 0;

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(4)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .IReq(IReq), .IAddr(IAddr), .IGnt(IGnt), .IValid(IValid), .IData(IData),
    .DReq(DReq), .DWr(DWr), .DAddr(DAddr), .DWData(DWData),
    .DGnt(DGnt), .DValid(DValid), .DRData(DRData),
    .MemAddr(MemAddr), .MemWr(MemWr), .MemWData(MemWData), .MemRData(MemRData),
    .Busy(Busy)
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut_lat1 (
    .Clk(Clk), .Reset(Reset),
    .IReq(IReq), .IAddr(IAddr), .IGnt(q_ignt), .IValid(q_ivalid), .IData(q_idata),
    .DReq(DReq), .DWr(DWr), .DAddr(DAddr), .DWData(DWData),
    .DGnt(q_dgnt), .DValid(q_dvalid), .DRData(q_drdata),
    .MemAddr(q_memaddr), .MemWr(q_memwr), .MemWData(q_memwdata), .MemRData(q_memrdata),
    .Busy(q_busy)
  );

  initial forever #5 Clk = ~Clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory returns real data only once an address has been held for LAT cycles.
  logic [31:0] prev_addr = '0;
  int          run_q = 0;
  int          run_now;
  always_comb begin
    run_now = 0;
    if (MemAddr != 32'd0) run_now = (MemAddr == prev_addr) ? run_q + 1 : 1;
  end
  assign MemRData = (run_now >= LAT) ? memf(MemAddr) : 32'hBAD0_BAD0;
  always @(posedge Clk) begin
    prev_addr <= MemAddr;
    run_q     <= run_now;
  end
  assign q_memrdata = (q_memaddr != 32'd0) ? memf(q_memaddr) : 32'hBAD0_BAD0;

  // Reference model: one transaction at a time, described by its cycle offset from ACCESS.
  logic        m_active = 1'b0;
  int          m_off = 0;
  logic        m_fetch = 1'b0;
  logic        m_wr = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] e_idata = '0;
  logic [31:0] e_drdata = '0;
`ifdef MEM_ARB_FAIRNESS_EN
  int          m_starve = 0;
  function automatic logic fetch_wins(input logic ireq, input logic dreq, input int starve);
    return ireq && (!dreq || starve >= STARVE);
  endfunction
`else
  function automatic logic fetch_wins(input logic ireq, input logic dreq);
    return ireq && !dreq;
  endfunction
`endif

  function automatic int resp_off(input logic wr, input int lat);
    return wr ? 1 : lat;
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_active <= 1'b0;
      m_off    <= 0;
      m_fetch  <= 1'b0;
      m_wr     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      e_idata  <= '0;
      e_drdata <= '0;
`ifdef MEM_ARB_FAIRNESS_EN
      m_starve <= 0;
`endif
    end else if (m_active) begin
      if (m_off == resp_off(m_wr, LAT)) begin
        m_active <= 1'b0;
      end else begin
        m_off <= m_off + 1;
        if (m_off + 1 == resp_off(m_wr, LAT)) begin
          if (m_fetch) e_idata  <= memf(m_addr);
          else         e_drdata <= m_wr ? 32'd0 : memf(m_addr);
        end
      end
    end else if (IReq || DReq) begin
      m_active <= 1'b1;
      m_off    <= 0;
`ifdef MEM_ARB_FAIRNESS_EN
      m_fetch  <= fetch_wins(IReq, DReq, m_starve);
      m_wr     <= !fetch_wins(IReq, DReq, m_starve) && DWr;
      m_addr   <= fetch_wins(IReq, DReq, m_starve) ? IAddr : DAddr;
      m_wdata  <= fetch_wins(IReq, DReq, m_starve) ? 32'd0 : DWData;
      m_starve <= (fetch_wins(IReq, DReq, m_starve) || !IReq) ? 0 : m_starve + 1;
`else
      m_fetch  <= fetch_wins(IReq, DReq);
      m_wr     <= !fetch_wins(IReq, DReq) && DWr;
      m_addr   <= fetch_wins(IReq, DReq) ? IAddr : DAddr;
      m_wdata  <= fetch_wins(IReq, DReq) ? 32'd0 : DWData;
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  task automatic run_checks();
    logic acc, wt, rsp, drv;
    int   last;
    last = resp_off(m_wr, LAT);
    acc  = m_active && (m_off == 0);
    wt   = m_active && (m_off > 0) && (m_off < last);
    rsp  = m_active && (m_off == last);
    drv  = acc || wt;
    chk1("busy", Busy, m_active);
    chk1("ignt", IGnt, acc && m_fetch);
    chk1("dgnt", DGnt, acc && !m_fetch);
    chk1("memwr", MemWr, acc && m_wr);
    chk("memaddr", MemAddr, drv ? m_addr : 32'd0);
    chk("memwdata", MemWData, drv ? m_wdata : 32'd0);
    chk1("ivalid", IValid, rsp && m_fetch);
    chk1("dvalid", DValid, rsp && !m_fetch);
    chk("idata", IData, e_idata);
    chk("drdata", DRData, e_drdata);
  endtask

  task automatic tick();
    @(negedge Clk);
    run_checks();
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (m_active && budget < 40) begin
      tick();
      budget++;
    end
    if (m_active) begin
      n_checks++;
      n_fail++;
      $error("FAIL drain_timeout observed=busy expected=idle");
    end
    tick();
  endtask

  initial begin
    logic exp_i;
    int   grants;
    int   budget;

    repeat (3) @(negedge Clk);
    chk1("rst_busy", Busy, 1'b0);
    chk("rst_memaddr", MemAddr, 32'd0);
    chk1("rst_ignt", IGnt, 1'b0);
    chk1("rst_dvalid", DValid, 1'b0);
    chk("rst_idata", IData, 32'd0);
    Reset = 1'b1;
    tick();

    // MEM_LAT=1 instance: ACCESS straight to RESP.
    DReq = 1'b1; DWr = 1'b0; DAddr = 32'h44; DWData = 32'h77;
    tick();
    chk1("l1_dgnt", q_dgnt, 1'b1);
    chk("l1_memaddr_acc", q_memaddr, 32'h44);
    DReq = 1'b0;
    tick();
    chk1("l1_dvalid", q_dvalid, 1'b1);
    chk("l1_drdata", q_drdata, memf(32'h44));
    chk("l1_memaddr_resp", q_memaddr, 32'd0);
    tick();
    chk1("l1_dvalid_pulse", q_dvalid, 1'b0);
    drain();

    // Fetch read of 0xDEADBEEF.
    IReq = 1'b1; IAddr = 32'h100;
    tick();
    chk1("f_ignt", IGnt, 1'b1);
    IReq = 1'b0;
    tick();
    tick();
    chk1("f_ivalid", IValid, 1'b1);
    chk("f_idata", IData, 32'hDEADBEEF);
    drain();

    // Single-cycle data write.
    DReq = 1'b1; DWr = 1'b1; DAddr = 32'h20; DWData = 32'h55;
    tick();
    chk1("w_memwr", MemWr, 1'b1);
    chk("w_memaddr", MemAddr, 32'h20);
    chk("w_memwdata", MemWData, 32'h55);
    DReq = 1'b0; DWr = 1'b0;
    tick();
    chk1("w_memwr_off", MemWr, 1'b0);
    chk1("w_dvalid", DValid, 1'b1);
    chk("w_drdata", DRData, 32'd0);
    drain();

    // Simultaneous requests: data first, fetch on the next access.
    IReq = 1'b1; IAddr = 32'h200; DReq = 1'b1; DWr = 1'b0; DAddr = 32'h300;
    tick();
    chk1("both_dgnt", DGnt, 1'b1);
    chk1("both_ignt0", IGnt, 1'b0);
    DReq = 1'b0;
    tick(); tick(); tick();
    chk1("both_idle_ignt", IGnt, 1'b0);
    tick();
    chk1("both_ignt1", IGnt, 1'b1);
    IReq = 1'b0;
    drain();

    // Both held high: grant order.
    IReq = 1'b1; IAddr = 32'h400; DReq = 1'b1; DWr = 1'b1; DAddr = 32'h500; DWData = 32'hA5;
    grants = 0;
    budget = 0;
    while (grants < 6 && budget < 60) begin
      tick();
      budget++;
      if (IGnt || DGnt) begin
`ifdef MEM_ARB_FAIRNESS_EN
        exp_i = ((grants % (STARVE + 1)) == STARVE);
`else
        exp_i = 1'b0;
`endif
        chk1($sformatf("order_%0d", grants), IGnt, exp_i);
        grants++;
      end
    end
    if (grants < 6) begin
      n_checks++;
      n_fail++;
      $error("FAIL order_timeout observed=%0d expected=6", grants);
    end
    IReq = 1'b0; DReq = 1'b0; DWr = 1'b0;
    drain();

    // Reset during WAIT of a read.
    DReq = 1'b1; DWr = 1'b0; DAddr = 32'h80;
    tick();
    DReq = 1'b0;
    tick();
    Reset = 1'b0;
    #1;
    chk1("mid_rst_busy", Busy, 1'b0);
    chk("mid_rst_memaddr", MemAddr, 32'd0);
    chk("mid_rst_drdata", DRData, 32'd0);
    tick();
    tick();
    Reset = 1'b1; IReq = 1'b1; IAddr = 32'h100;
    tick();
    chk1("post_rst_ignt", IGnt, 1'b1);
    IReq = 1'b0;
    tick();
    tick();
    chk1("post_rst_ivalid", IValid, 1'b1);
    chk("post_rst_idata", IData, 32'hDEADBEEF);
    drain();

    // Random traffic; requesters hold until their grant.
    for (int c = 0; c < 1200; c++) begin
      tick();
      if (m_active && m_off == 0) begin
        if (m_fetch) IReq = 1'b0;
        else         DReq = 1'b0;
      end
      if (!IReq && $urandom_range(99) < 35) begin
        IReq  = 1'b1;
        IAddr = ($urandom() & 32'hFFFF_FFFC) | 32'h4;
      end
      if (!DReq && $urandom_range(99) < 40) begin
        DReq   = 1'b1;
        DWr    = 1'($urandom_range(1));
        DAddr  = ($urandom() & 32'hFFFF_FFFC) | 32'h8;
        DWData = $urandom();
      end
    end
    IReq = 1'b0; DReq = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
